actor_move_scheduler: RTL and testbench

- Time-multiplexes the single map_lut wall-lookup port between N_ACTORS actors (actor 0 = Pac-Man, actors 1..4 = ghosts).
- On each game tick, steps every actor once in fixed order 0..N_ACTORS-1: computes the candidate next tile, queries the map, commits the move or blocks it.
- Sits between the direction sources (input decoder, ghost AI) and the renderer. Owns all actor position registers.

---
 rtl/pacman_move_pkg.sv | 24 ++
 rtl/move_next_pos.sv | 45 ++++
 rtl/actor_move_scheduler.sv | 177 +++++++++++++++++
 tb/tb_actor_move_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_move_pkg.sv
// Shared types and constants for the actor movement scheduler:
// direction codes, maze extents, coordinate widths and FSM states.
package pacman_move_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [X_W-1:0] X_MAX = 8'd26;
    localparam logic [Y_W-1:0] Y_MAX = 7'd23;

    localparam logic [2:0] RIGHT = 3'd0;
    localparam logic [2:0] UP    = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] DOWN  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAITQ,
        S_DONE
    } state_t;

endpackage

// File: rtl/move_next_pos.sv
// Combinational next-tile calculator: one step in dir with tunnel wrap at
// the maze edges. Codes 5-7 behave as WAIT.
module move_next_pos
    import pacman_move_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [2:0]     dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           wrap,
    output logic           needs_lookup
);

    always_comb begin
        nx           = x;
        ny           = y;
        wrap         = 1'b0;
        needs_lookup = 1'b0;
        case (dir)
            RIGHT: if (x == X_MAX) begin
                       nx = '0; wrap = 1'b1;
                   end else begin
                       nx = x + X_W'(1); needs_lookup = 1'b1;
                   end
            LEFT:  if (x == '0) begin
                       nx = X_MAX; wrap = 1'b1;
                   end else begin
                       nx = x - X_W'(1); needs_lookup = 1'b1;
                   end
            UP:    if (y == '0) begin
                       ny = Y_MAX; wrap = 1'b1;
                   end else begin
                       ny = y - Y_W'(1); needs_lookup = 1'b1;
                   end
            DOWN:  if (y == Y_MAX) begin
                       ny = '0; wrap = 1'b1;
                   end else begin
                       ny = y + Y_W'(1); needs_lookup = 1'b1;
                   end
            default: ;
        endcase
    end

endmodule

// File: rtl/actor_move_scheduler.sv
// Steps every actor once per game tick through the shared map_lut port.
// Optional collision outputs are built when COLLISION_DETECT_EN is defined.
module actor_move_scheduler
    import pacman_move_pkg::*;
#(
    parameter int N_ACTORS = 5,
    parameter int MAP_LAT  = 1,
    parameter logic [8*N_ACTORS-1:0] START_X = {5{8'd13}},
    parameter logic [7*N_ACTORS-1:0] START_Y = {7'd17, {4{7'd11}}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  restart,
    input  logic [3*N_ACTORS-1:0] dir_in,
    output logic                  map_req,
    output logic [X_W-1:0]        map_x,
    output logic [Y_W-1:0]        map_y,
    input  logic                  map_q,
    output logic [8*N_ACTORS-1:0] x_out,
    output logic [7*N_ACTORS-1:0] y_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
`ifdef COLLISION_DETECT_EN
    ,
    output logic                  collision,
    output logic [N_ACTORS-1:0]   collide_mask
`endif
);

    localparam int IW = (N_ACTORS > 1) ? $clog2(N_ACTORS) : 1;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [1:0]            lat_cnt;
    logic [3*N_ACTORS-1:0] snap;
    logic [X_W-1:0]        px [N_ACTORS];
    logic [Y_W-1:0]        py [N_ACTORS];

    logic [IW-1:0]  nxt_sel;
    logic [2:0]     nxt_dir;
    logic [X_W-1:0] c_nx;
    logic [Y_W-1:0] c_ny;
    logic           c_wrap;
    logic           c_look;
    logic           step_done;

    // The next actor's lookup is prepared at the edge that enters its ISSUE
    // slot, so map_req/map_x/map_y can be plain registers.
    always_comb begin
        nxt_sel = (state == S_IDLE) ? '0 : idx + IW'(1);
        if (nxt_sel > IW'(N_ACTORS - 1))
            nxt_sel = '0;
        nxt_dir = (state == S_IDLE) ? dir_in[2:0] : snap[3*nxt_sel +: 3];
    end

    move_next_pos u_next_pos (
        .x            (px[nxt_sel]),
        .y            (py[nxt_sel]),
        .dir          (nxt_dir),
        .nx           (c_nx),
        .ny           (c_ny),
        .wrap         (c_wrap),
        .needs_lookup (c_look)
    );

    assign step_done = ((state == S_ISSUE) && (MAP_LAT == 0)) ||
                       ((state == S_WAITQ) && (lat_cnt == 2'(MAP_LAT)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            lat_cnt    <= '0;
            snap       <= '0;
            map_req    <= 1'b0;
            map_x      <= '0;
            map_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned k = 0; k < N_ACTORS; k++) begin
                px[k] <= START_X[8*k +: 8];
                py[k] <= START_Y[7*(N_ACTORS-1-k) +: 7];
            end
        end else if (restart) begin
            state      <= S_IDLE;
            idx        <= '0;
            lat_cnt    <= '0;
            map_req    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned k = 0; k < N_ACTORS; k++) begin
                px[k] <= START_X[8*k +: 8];
                py[k] <= START_Y[7*(N_ACTORS-1-k) +: 7];
            end
        end else begin
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (tick) begin
                    snap    <= dir_in;
                    idx     <= '0;
                    busy    <= 1'b1;
                    state   <= S_ISSUE;
                    map_req <= c_look & ~c_wrap;
                    map_x   <= c_nx;
                    map_y   <= c_ny;
                end
                S_ISSUE: if (MAP_LAT != 0) begin
                    lat_cnt <= 2'd1;
                    state   <= S_WAITQ;
                end
                S_WAITQ: if (!step_done)
                    lat_cnt <= lat_cnt + 2'd1;
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Commit edge: map_x/map_y already hold the candidate (or the
            // unchanged/wrapped tile when no lookup was made).
            if (step_done) begin
                if (!map_req || !map_q) begin
                    px[idx] <= map_x;
                    py[idx] <= map_y;
                end
                if (idx == IW'(N_ACTORS - 1)) begin
                    state      <= S_DONE;
                    frame_done <= 1'b1;
                    map_req    <= 1'b0;
                end else begin
                    idx     <= idx + IW'(1);
                    state   <= S_ISSUE;
                    map_req <= c_look & ~c_wrap;
                    map_x   <= c_nx;
                    map_y   <= c_ny;
                end
            end
        end
    end

    always_comb begin
        x_out = '0;
        y_out = '0;
        for (int unsigned k = 0; k < N_ACTORS; k++) begin
            x_out[8*k +: 8] = px[k];
            y_out[7*k +: 7] = py[k];
        end
    end

`ifdef COLLISION_DETECT_EN
    logic [N_ACTORS-1:0] mask_now;

    always_comb begin
        mask_now = '0;
        for (int unsigned k = 1; k < N_ACTORS; k++)
            mask_now[k] = (px[k] == px[0]) && (py[k] == py[0]);
    end

    assign collision = frame_done & (|mask_now);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            collide_mask <= '0;
        else if (restart)
            collide_mask <= '0;
        else if (state == S_DONE)
            collide_mask <= mask_now;
    end
`endif

endmodule

// File: tb/tb_actor_move_scheduler.sv
// Directed self-checking bench for actor_move_scheduler (default parameters).
module tb_actor_move_scheduler;

    localparam logic [39:0] SX = {5{8'd13}};
    localparam logic [34:0] SY = {7'd11, 7'd11, 7'd11, 7'd11, 7'd17};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        restart = 1'b0;
    logic [14:0] dir_in = {5{3'd4}};
    logic        map_req;
    logic [7:0]  map_x;
    logic [6:0]  map_y;
    logic        map_q;
    logic [39:0] x_out;
    logic [34:0] y_out;
    logic        busy, frame_done, overrun;
    logic        wall = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int dc;

    logic       req_r [0:31];
    logic [7:0] mx_r  [0:31];
    logic [6:0] my_r  [0:31];
    logic [7:0] x0_r  [0:31];

    assign map_q = wall;

    always #5 clk = ~clk;

    actor_move_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .restart    (restart),
        .dir_in     (dir_in),
        .map_req    (map_req),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_q      (map_q),
        .x_out      (x_out),
        .y_out      (y_out),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    function automatic logic [14:0] pack(input logic [2:0] d0, d1, d2, d3, d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    task automatic run_frame(input logic [14:0] dirs, input logic w,
                             input int extra, output int done_c);
        for (int i = 0; i < 32; i++) begin
            req_r[i] = 1'b0; mx_r[i] = '0; my_r[i] = '0; x0_r[i] = '0;
        end
        dir_in = dirs;
        wall   = w;
        @(negedge clk) tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        done_c = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req_r[c] = map_req;
            mx_r[c]  = map_x;
            my_r[c]  = map_y;
            x0_r[c]  = x_out[7:0];
            tick = (c == extra);
            if (frame_done) begin
                done_c = c;
                break;
            end
        end
        tick = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    task automatic test_reset();
        nvec++; if (x_out !== SX) begin nerr++; $display("FAIL reset_x: got %h expected %h", x_out, SX); end
        nvec++; if (y_out !== SY) begin nerr++; $display("FAIL reset_y: got %h expected %h", y_out, SY); end
        nvec++; if ({busy, frame_done, map_req, overrun} !== 4'b0) begin nerr++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, frame_done, map_req, overrun}); end
        nvec++; if ({map_x, map_y} !== 15'd0) begin nerr++; $display("FAIL reset_map_xy: got %h expected 0", {map_x, map_y}); end
    endtask

    task automatic test_all_wait();
        int nreq = 0;
        run_frame({5{3'd4}}, 1'b0, 0, dc);
        for (int c = 1; c <= 11; c++) nreq += int'(req_r[c]);
        nvec++; if (dc !== 11) begin nerr++; $display("FAIL wait_done_cycle: got %0d expected 11", dc); end
        nvec++; if (nreq !== 0) begin nerr++; $display("FAIL wait_no_req: got %0d requests expected 0", nreq); end
        nvec++; if (x_out !== SX || y_out !== SY) begin nerr++;
            $display("FAIL wait_positions: got %h/%h expected %h/%h", x_out, y_out, SX, SY); end
    endtask

    task automatic test_move_right();
        run_frame(pack(3'd0, 3'd4, 3'd4, 3'd4, 3'd4), 1'b0, 0, dc);
        nvec++; if ({req_r[1], mx_r[1], my_r[1]} !== {1'b1, 8'd14, 7'd17}) begin nerr++;
            $display("FAIL right_req: got %b/%0d/%0d expected 1/14/17", req_r[1], mx_r[1], my_r[1]); end
        nvec++; if (req_r[2] !== 1'b1) begin nerr++; $display("FAIL right_req_hold: got %b expected 1", req_r[2]); end
        nvec++; if (x0_r[2] !== 8'd13) begin nerr++; $display("FAIL right_before_commit: got %0d expected 13", x0_r[2]); end
        nvec++; if (x0_r[3] !== 8'd14) begin nerr++; $display("FAIL right_after_commit: got %0d expected 14", x0_r[3]); end
        nvec++; if (req_r[3] !== 1'b0) begin nerr++; $display("FAIL right_slot1_idle: got %b expected 0", req_r[3]); end
        nvec++; if (x_out[7:0] !== 8'd14 || y_out[6:0] !== 7'd17) begin nerr++;
            $display("FAIL right_final: got %0d,%0d expected 14,17", x_out[7:0], y_out[6:0]); end
    endtask

    task automatic test_blocked();
        do_restart();
        nvec++; if (x_out !== SX) begin nerr++; $display("FAIL restart_reload: got %h expected %h", x_out, SX); end
        run_frame(pack(3'd0, 3'd3, 3'd4, 3'd4, 3'd4), 1'b1, 0, dc);
        nvec++; if ({req_r[1], mx_r[1]} !== {1'b1, 8'd14}) begin nerr++;
            $display("FAIL blocked_req0: got %b/%0d expected 1/14", req_r[1], mx_r[1]); end
        nvec++; if ({req_r[3], mx_r[3], my_r[3]} !== {1'b1, 8'd13, 7'd12}) begin nerr++;
            $display("FAIL blocked_req1: got %b/%0d/%0d expected 1/13/12", req_r[3], mx_r[3], my_r[3]); end
        nvec++; if (dc !== 11) begin nerr++; $display("FAIL blocked_done_cycle: got %0d expected 11", dc); end
        nvec++; if (x_out !== SX || y_out !== SY) begin nerr++;
            $display("FAIL blocked_positions: got %h/%h expected %h/%h", x_out, y_out, SX, SY); end
    endtask

    task automatic test_wrap();
        int nreq;
        do_restart();
        for (int f = 0; f < 11; f++) begin
            run_frame(pack(3'd4, 3'd4, 3'd0, 3'd1, 3'd4), 1'b0, 0, dc);
            if (f == 0) begin
                nvec++; if ({mx_r[5], my_r[7]} !== {8'd14, 7'd10}) begin nerr++;
                    $display("FAIL wrap_first_cand: got %0d,%0d expected 14,10", mx_r[5], my_r[7]); end
            end
        end
        nvec++; if (x_out[23:16] !== 8'd24 || y_out[27:21] !== 7'd0) begin nerr++;
            $display("FAIL wrap_approach: got %0d,%0d expected 24,0", x_out[23:16], y_out[27:21]); end
        for (int f = 0; f < 2; f++)
            run_frame(pack(3'd4, 3'd4, 3'd0, 3'd4, 3'd4), 1'b0, 0, dc);
        nvec++; if (x_out[23:16] !== 8'd26) begin nerr++; $display("FAIL wrap_x_edge: got %0d expected 26", x_out[23:16]); end
        run_frame(pack(3'd4, 3'd4, 3'd0, 3'd1, 3'd4), 1'b1, 0, dc);
        nreq = 0;
        for (int c = 5; c <= 8; c++) nreq += int'(req_r[c]);
        nvec++; if (nreq !== 0) begin nerr++; $display("FAIL wrap_no_req: got %0d requests expected 0", nreq); end
        nvec++; if (x_out[23:16] !== 8'd0 || y_out[27:21] !== 7'd23) begin nerr++;
            $display("FAIL wrap_right_up: got %0d,%0d expected 0,23", x_out[23:16], y_out[27:21]); end
        nvec++; if (dc !== 11) begin nerr++; $display("FAIL wrap_done_cycle: got %0d expected 11", dc); end
        run_frame(pack(3'd4, 3'd4, 3'd2, 3'd3, 3'd4), 1'b1, 0, dc);
        nreq = 0;
        for (int c = 5; c <= 8; c++) nreq += int'(req_r[c]);
        nvec++; if (nreq !== 0 || x_out[23:16] !== 8'd26 || y_out[27:21] !== 7'd0) begin nerr++;
            $display("FAIL wrap_left_down: got req=%0d %0d,%0d expected req=0 26,0", nreq, x_out[23:16], y_out[27:21]); end
    endtask

    task automatic test_overrun();
        do_restart();
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
        run_frame(pack(3'd0, 3'd4, 3'd4, 3'd4, 3'd4), 1'b0, 5, dc);
        nvec++; if (dc !== 11) begin nerr++; $display("FAIL overrun_done_cycle: got %0d expected 11", dc); end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        nvec++; if (x_out[7:0] !== 8'd14) begin nerr++; $display("FAIL overrun_frame: got %0d expected 14", x_out[7:0]); end
        repeat (3) @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL overrun_no_refire: got busy=%b expected 0", busy); end
        // restart and tick together: restart wins
        @(negedge clk) begin restart = 1'b1; tick = 1'b1; end
        @(negedge clk) begin restart = 1'b0; tick = 1'b0; end
        nvec++; if ({busy, overrun} !== 2'b00) begin nerr++;
            $display("FAIL restart_tick: got busy,overrun=%b expected 00", {busy, overrun}); end
        nvec++; if (x_out !== SX || y_out !== SY) begin nerr++;
            $display("FAIL restart_positions: got %h/%h expected %h/%h", x_out, y_out, SX, SY); end
    endtask

    task automatic test_async_reset();
        dir_in = pack(3'd0, 3'd3, 3'd4, 3'd4, 3'd4);
        wall   = 1'b0;
        @(negedge clk) tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (4) @(negedge clk);
        nvec++; if ({map_req, x_out[7:0]} !== {1'b1, 8'd14}) begin nerr++;
            $display("FAIL areset_pre: got req=%b x0=%0d expected 1/14", map_req, x_out[7:0]); end
        #2 reset_n = 1'b0;
        #1;
        nvec++; if (x_out !== SX || y_out !== SY) begin nerr++;
            $display("FAIL areset_pos: got %h/%h expected %h/%h", x_out, y_out, SX, SY); end
        nvec++; if ({busy, frame_done, map_req, overrun, map_x, map_y} !== 19'd0) begin nerr++;
            $display("FAIL areset_outs: got %b expected all zero", {busy, frame_done, map_req, overrun, map_x, map_y}); end
        @(negedge clk) reset_n = 1'b1;
        run_frame(pack(3'd0, 3'd4, 3'd4, 3'd4, 3'd4), 1'b0, 0, dc);
        nvec++; if ({req_r[1], mx_r[1]} !== {1'b1, 8'd14} || dc !== 11) begin nerr++;
            $display("FAIL areset_rerun: got req=%b x=%0d done=%0d expected 1/14/11", req_r[1], mx_r[1], dc); end
        nvec++; if (x_out[7:0] !== 8'd14) begin nerr++; $display("FAIL areset_rerun_pos: got %0d expected 14", x_out[7:0]); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_all_wait();
        test_move_right();
        test_blocked();
        test_wrap();
        test_overrun();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
